led_pattern_engine: RTL and testbench

Parametrised successor to the per-mode LED animators (scan spot, life bar, alternating flash). One registered engine drives an N_LED-wide LED bank from a selectable mode. It has an internal step prescaler, so no separate flash clock is needed, and a finite-burst flash that reports completion. It sits between the game FSM, which issues mode loads, and the board LED pins.

---
 rtl/led_pattern_engine_pkg.sv | 29 ++
 rtl/led_pattern_engine_tick_prescaler.sv | 25 ++
 rtl/led_pattern_engine.sv | 144 ++++++++++++++
 tb/tb_led_pattern_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_engine_pkg.sv
// Shared mode encodings, widths and pattern helpers for led_pattern_engine.
package led_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_SCAN   = 3'd1,
        MODE_BAR    = 3'd2,
        MODE_FLASH  = 3'd3,
        MODE_BOUNCE = 3'd4
    } mode_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    localparam int BURST_W = 8;
    localparam int MAX_LED = 64;

    // Pattern A: MSB set, bits alternating downward (1010... for width 10).
    function automatic logic [MAX_LED-1:0] alt_pattern(input int width);
        logic [MAX_LED-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_LED; i++)
            if (i < width && ((width - 1 - i) % 2) == 0) p[i] = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/led_pattern_engine_tick_prescaler.sv
// Free-running step generator: step is high for one cycle every TICK_DIV cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic step
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign step = (count == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            count <= '0;
        else if (clear || step)
            count <= '0;
        else
            count <= count + 1'b1;
    end
endmodule

// File: rtl/led_pattern_engine.sv
// Multi-mode LED animator (OFF/SCAN/BAR/FLASH, plus BOUNCE when
// LED_PATTERN_BOUNCE_EN is defined) with an internal step prescaler.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter  int N_LED    = 10,
    parameter  int TICK_DIV = 4,
    localparam int LW       = $clog2(N_LED + 1)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [2:0]         mode,
    input  logic               mode_load,
    input  logic [LW-1:0]      level,
    input  logic [BURST_W-1:0] burst_count,
    output logic [N_LED-1:0]   led,
    output logic               busy,
    output logic               done
);
    localparam int PW = $clog2(N_LED);
    localparam logic [PW-1:0]      POS_TOP  = PW'(N_LED - 1);
    localparam logic [MAX_LED-1:0] PAT_FULL = alt_pattern(N_LED);
    localparam logic [N_LED-1:0]   PAT_A    = PAT_FULL[N_LED-1:0];
    localparam logic [N_LED-1:0]   SPOT_TOP = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0]   ONE      = N_LED'(1);

    mode_e              cur_mode, load_mode;
    logic [PW-1:0]      pos, pos_nxt;
    logic [BURST_W-1:0] remaining;
    logic [N_LED-1:0]   bar;
    logic               step;
`ifdef LED_PATTERN_BOUNCE_EN
    dir_e               dir, dir_nxt;
`endif

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock  (clock),
        .resetn (resetn),
        .clear  (mode_load),
        .step   (step)
    );

    // Unsupported encodings collapse to OFF at load time.
    always_comb begin
        case (mode)
            MODE_SCAN:   load_mode = MODE_SCAN;
            MODE_BAR:    load_mode = MODE_BAR;
            MODE_FLASH:  load_mode = MODE_FLASH;
`ifdef LED_PATTERN_BOUNCE_EN
            MODE_BOUNCE: load_mode = MODE_BOUNCE;
`endif
            default:     load_mode = MODE_OFF;
        endcase
    end

    always_comb begin
        bar = '0;
        for (int i = 0; i < N_LED; i++)
            bar[i] = (int'(level) >= N_LED - i);
    end

    always_comb begin
        pos_nxt = (pos == '0) ? POS_TOP : pos - 1'b1;
`ifdef LED_PATTERN_BOUNCE_EN
        dir_nxt = dir;
        if (cur_mode == MODE_BOUNCE) begin
            if (dir == DIR_RIGHT) begin
                if (pos == '0) begin
                    pos_nxt = PW'(1);
                    dir_nxt = DIR_LEFT;
                end
            end else if (pos == POS_TOP) begin
                pos_nxt = POS_TOP - 1'b1;
                dir_nxt = DIR_RIGHT;
            end else begin
                pos_nxt = pos + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur_mode  <= MODE_OFF;
            led       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pos       <= POS_TOP;
            remaining <= '0;
`ifdef LED_PATTERN_BOUNCE_EN
            dir       <= DIR_RIGHT;
`endif
        end else begin
            done <= 1'b0;
            if (mode_load) begin
                // A load outranks any step pending in the same cycle.
                cur_mode  <= load_mode;
                pos       <= POS_TOP;
                remaining <= burst_count;
                busy      <= (load_mode != MODE_OFF);
`ifdef LED_PATTERN_BOUNCE_EN
                dir       <= DIR_RIGHT;
`endif
                case (load_mode)
                    MODE_SCAN, MODE_BOUNCE: led <= SPOT_TOP;
                    MODE_BAR:               led <= bar;
                    MODE_FLASH:             led <= PAT_A;
                    default:                led <= '0;
                endcase
            end else begin
                case (cur_mode)
                    MODE_SCAN, MODE_BOUNCE: begin
                        if (step) begin
                            pos <= pos_nxt;
                            led <= ONE << pos_nxt;
`ifdef LED_PATTERN_BOUNCE_EN
                            dir <= dir_nxt;
`endif
                        end
                    end
                    MODE_BAR: led <= bar;
                    MODE_FLASH: begin
                        if (step) begin
                            if (remaining == BURST_W'(1)) begin
                                cur_mode  <= MODE_OFF;
                                led       <= '0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                remaining <= '0;
                            end else begin
                                led <= ~led;
                                if (remaining != '0) remaining <= remaining - 1'b1;
                            end
                        end
                    end
                    default: begin
                        led  <= '0;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (N_LED=10, TICK_DIV=4): vector table,
// corner-case sequences and randomized traffic against a closed-form reference model.
module tb_led_pattern_engine;
    localparam int N  = 10;
    localparam int TD = 4;
    localparam int LW = $clog2(N + 1);
`ifdef LED_PATTERN_BOUNCE_EN
    localparam bit BOUNCE_EN = 1'b1;
`else
    localparam bit BOUNCE_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [2:0]    mode = '0;
    logic          mode_load = 1'b0;
    logic [LW-1:0] level = '0;
    logic [7:0]    burst_count = '0;
    logic [N-1:0]  led;
    logic          busy, done;

    always #5 clock = ~clock;

    led_pattern_engine #(.N_LED(N), .TICK_DIV(TD)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .mode        (mode),
        .mode_load   (mode_load),
        .level       (level),
        .burst_count (burst_count),
        .led         (led),
        .busy        (busy),
        .done        (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state is just "what was loaded and how many edges ago".
    int m_mode  = 0;
    int m_cyc   = 0;
    int m_burst = 0;
    int m_level = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_out(output logic [N-1:0] e_led, output logic e_busy,
                                      output logic e_done);
        int k, p, idx;
        logic [N-1:0] pat;
        k = m_cyc / TD;
        e_led = '0; e_busy = 1'b0; e_done = 1'b0;
        pat = '0;
        for (int i = 0; i < N; i++) pat[i] = ((N - 1 - i) % 2) == 0;
        case (m_mode)
            1: begin e_led[N - 1 - (k % N)] = 1'b1; e_busy = 1'b1; end
            2: begin
                for (int i = 0; i < N; i++) e_led[i] = (N - i) <= m_level;
                e_busy = 1'b1;
            end
            3: begin
                if (m_burst != 0 && k >= m_burst)
                    e_done = (m_cyc == m_burst * TD);
                else begin
                    e_led  = (k % 2 == 1) ? ~pat : pat;
                    e_busy = 1'b1;
                end
            end
            4: if (BOUNCE_EN) begin
                p   = k % (2 * (N - 1));
                idx = (p < N) ? (N - 1 - p) : (p - (N - 1));
                e_led[idx] = 1'b1;
                e_busy = 1'b1;
            end
            default: ;
        endcase
    endfunction

    // One clock: update the model from the inputs seen at the edge, then compare.
    task automatic cycle();
        logic [N-1:0] el;
        logic eb, ed;
        @(posedge clock);
        if (mode_load) begin
            m_mode = int'(mode); m_cyc = 0; m_burst = int'(burst_count);
        end else begin
            m_cyc++;
        end
        m_level = int'(level);
        #1;
        model_out(el, eb, ed);
        chk("model_led", 32'(led), 32'(el));
        chk("model_busy", 32'(busy), 32'(eb));
        chk("model_done", 32'(done), 32'(ed));
    endtask

    task automatic load(input int m, input int b);
        mode = 3'(m); burst_count = 8'(b); mode_load = 1'b1;
        cycle();
        mode_load = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 resetn = 1'b0;
        m_mode = 0; m_cyc = 0; m_burst = 0;
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    typedef struct {
        bit         ld;
        logic [2:0] mode;
        logic [7:0] burst;
        logic [3:0] level;
        int         ncyc;
        logic [9:0] e_led;
        bit         e_busy;
        bit         e_done;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1, 3'd1, 8'd0, 4'd0,  1, 10'b1000000000, 1, 0};
        tbl[1]  = '{0, 3'd0, 8'd0, 4'd0,  4, 10'b0100000000, 1, 0};
        tbl[2]  = '{0, 3'd0, 8'd0, 4'd0, 36, 10'b1000000000, 1, 0};
        tbl[3]  = '{1, 3'd2, 8'd0, 4'd3,  1, 10'b1110000000, 1, 0};
        tbl[4]  = '{0, 3'd0, 8'd0, 4'd10, 1, 10'b1111111111, 1, 0};
        tbl[5]  = '{0, 3'd0, 8'd0, 4'd15, 1, 10'b1111111111, 1, 0};
        tbl[6]  = '{0, 3'd0, 8'd0, 4'd0,  1, 10'b0000000000, 1, 0};
        tbl[7]  = '{1, 3'd3, 8'd3, 4'd0,  1, 10'b1010101010, 1, 0};
        tbl[8]  = '{0, 3'd0, 8'd0, 4'd0,  4, 10'b0101010101, 1, 0};
        tbl[9]  = '{0, 3'd0, 8'd0, 4'd0,  4, 10'b1010101010, 1, 0};
        tbl[10] = '{0, 3'd0, 8'd0, 4'd0,  3, 10'b1010101010, 1, 0};
        tbl[11] = '{0, 3'd0, 8'd0, 4'd0,  1, 10'b0000000000, 0, 1};
        tbl[12] = '{0, 3'd0, 8'd0, 4'd0,  1, 10'b0000000000, 0, 0};
        tbl[13] = '{0, 3'd0, 8'd0, 4'd0,  8, 10'b0000000000, 0, 0};
        tbl[14] = '{1, 3'd6, 8'd0, 4'd0,  1, 10'b0000000000, 0, 0};

        // Reset state
        #12;
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        repeat (3) cycle();

        // Vector table: SCAN, BAR saturation, finite FLASH burst, invalid mode
        for (int v = 0; v < 15; v++) begin
            level = LW'(tbl[v].level);
            mode = tbl[v].mode; burst_count = tbl[v].burst; mode_load = tbl[v].ld;
            cycle();
            mode_load = 1'b0;
            for (int c = 1; c < tbl[v].ncyc; c++) cycle();
            chk($sformatf("vec%0d_led", v), 32'(led), 32'(tbl[v].e_led));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(tbl[v].e_busy));
            chk($sformatf("vec%0d_done", v), 32'(done), 32'(tbl[v].e_done));
        end

        // Load coinciding with a prescaler step: the step is dropped
        load(1, 0);
        repeat (3) cycle();
        load(1, 0);
        chk("coll_no_step", 32'(led), 32'b1000000000);
        repeat (3) cycle();
        chk("coll_hold", 32'(led), 32'b1000000000);
        cycle();
        chk("coll_first_step", 32'(led), 32'b0100000000);

        // Reset mid-burst, then a reload restarts the full count
        load(3, 3);
        repeat (4) cycle();
        chk("burst_step1", 32'(led), 32'b0101010101);
        pulse_reset();
        repeat (16) cycle();
        chk("post_rst_done", 32'(done), 32'd0);
        load(3, 3);
        repeat (8) cycle();
        chk("reload_not_done", 32'(busy), 32'd1);
        repeat (4) cycle();
        chk("reload_done", 32'(done), 32'd1);

        // Mode 4
        load(4, 0);
        repeat (36) cycle();
        chk("bounce_bit0", 32'(led), BOUNCE_EN ? 32'b1 : 32'd0);
        repeat (4) cycle();
        chk("bounce_bit1", 32'(led), BOUNCE_EN ? 32'b10 : 32'd0);
        chk("bounce_busy", 32'(busy), BOUNCE_EN ? 32'd1 : 32'd0);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int ncyc;
            if ($urandom_range(0, 39) == 0) pulse_reset();
            if ($urandom_range(0, 2) != 0) begin
                level = LW'($urandom_range(0, 15));
                load(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
            end
            ncyc = int'($urandom_range(1, 30));
            for (int c = 0; c < ncyc; c++) begin
                if ($urandom_range(0, 3) == 0) level = LW'($urandom_range(0, 15));
                mode = 3'($urandom_range(0, 7));
                burst_count = 8'($urandom_range(0, 255));
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
